// File: rtl/perceptron_run_ctrl.sv
// Purpose: sequences the perceptron network's write/train/evaluate strobes across up to six letters and captures each result.
// Latency: the first strobe appears the cycle after start is sampled; a letter takes 2*PHASE_CYC+2 cycles.
// Backpressure: none; start is ignored while busy, and abort or reset returns the block to idle on the next cycle.
module perceptron_run_ctrl #(
    parameter int PHASE_CYC = 12,
    parameter int N_LETTERS = 6,
    parameter int OUT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             train_en,
    input  logic             abort,
    input  logic [OUT_W-1:0] net_out,
    output logic             write,
    output logic             atrain,
    output logic             gtrain,
    output logic             goa,
    output logic             gog,
    output logic [5:0]       letter_sel,
    output logic             busy,
    output logic             res_valid,
    output logic [2:0]       res_idx,
    output logic [OUT_W-1:0] res_data,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TRAIN,
        S_SEL,
        S_GOA,
        S_GOG,
        S_CAPT,
        S_DONE
    } state_t;

    localparam logic [7:0] PHASE_LAST  = 8'(PHASE_CYC - 1);
    localparam logic [2:0] LETTER_LAST = 3'(N_LETTERS - 1);

    state_t     state;
    state_t     nxt;
    logic [7:0] cnt;
    logic [7:0] nxt_cnt;
    logic [2:0] idx;
    logic [2:0] nxt_idx;
    logic       phase_end;
    logic       in_phase;
    logic       cap_en;

    logic       write_d;
    logic       train_d;
    logic       goa_d;
    logic       gog_d;
    logic [5:0] sel_d;
    logic       busy_d;
    logic       rv_d;
    logic [2:0] ridx_d;
    logic       done_d;

    assign phase_end = (cnt == PHASE_LAST);
    assign in_phase  = (state == S_WRITE) || (state == S_TRAIN) ||
                       (state == S_GOA)   || (state == S_GOG);
    assign cap_en    = (state == S_GOG) && phase_end && !abort;

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = train_en ? S_WRITE : S_SEL;
            S_WRITE: if (phase_end) nxt = S_TRAIN;
            S_TRAIN: if (phase_end) nxt = S_SEL;
            S_SEL:   nxt = S_GOA;
            S_GOA:   if (phase_end) nxt = S_GOG;
            S_GOG:   if (phase_end) nxt = S_CAPT;
            S_CAPT:  nxt = (idx == LETTER_LAST) ? S_DONE : S_SEL;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // abort has priority over everything, including a start seen in idle
        if (abort) nxt = S_IDLE;
    end

    always_comb begin
        nxt_idx = idx;
        if (nxt == S_IDLE) begin
            nxt_idx = 3'd0;
        end else if (state == S_CAPT && nxt == S_SEL) begin
            nxt_idx = idx + 3'd1;
        end

        nxt_cnt = cnt;
        if (nxt != state) begin
            nxt_cnt = 8'd0;
        end else if (in_phase && !phase_end) begin
            nxt_cnt = cnt + 8'd1;
        end
    end

    // outputs are decoded from the next state so they line up with the state they describe
    always_comb begin
        write_d = (nxt == S_WRITE);
        train_d = (nxt == S_TRAIN);
        goa_d   = (nxt == S_GOA);
        gog_d   = (nxt == S_GOG);
        busy_d  = (nxt != S_IDLE);
        done_d  = (nxt == S_DONE);
        rv_d    = (nxt == S_CAPT);
        ridx_d  = rv_d ? nxt_idx : 3'd0;
        sel_d   = 6'd0;
        if (nxt == S_SEL || nxt == S_GOA || nxt == S_GOG || nxt == S_CAPT) begin
            sel_d = 6'd1 << nxt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            idx        <= 3'd0;
            write      <= 1'b0;
            atrain     <= 1'b0;
            gtrain     <= 1'b0;
            goa        <= 1'b0;
            gog        <= 1'b0;
            letter_sel <= 6'd0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_idx    <= 3'd0;
            res_data   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= nxt_cnt;
            idx        <= nxt_idx;
            write      <= write_d;
            atrain     <= train_d;
            gtrain     <= train_d;
            goa        <= goa_d;
            gog        <= gog_d;
            letter_sel <= sel_d;
            busy       <= busy_d;
            res_valid  <= rv_d;
            res_idx    <= ridx_d;
            done       <= done_d;
            // res_data is held across abort; only a completed letter overwrites it
            if (cap_en) res_data <= net_out;
        end
    end

endmodule

// File: tb/tb_perceptron_run_ctrl.sv
// Bench for perceptron_run_ctrl: two instances (P=12,N=6 and P=1,N=2) driven with random runs,
// compared cycle by cycle against a timing model derived from the phase arithmetic.
module tb_perceptron_run_ctrl;

    logic       clk;
    logic [1:0] rst_v;
    logic [1:0] start_v;
    logic [1:0] tren_v;
    logic [1:0] abort_v;
    logic [7:0] net_v [2];

    wire [1:0] write_o, atrain_o, gtrain_o, goa_o, gog_o, busy_o, rv_o, done_o;
    wire [5:0] sel_o  [2];
    wire [2:0] ridx_o [2];
    wire [7:0] rdat   [2];
    wire [16:0] obs   [2];

    int errs;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    perceptron_run_ctrl #(.PHASE_CYC(12), .N_LETTERS(6), .OUT_W(8)) dut0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .train_en(tren_v[0]),
        .abort(abort_v[0]), .net_out(net_v[0]), .write(write_o[0]), .atrain(atrain_o[0]),
        .gtrain(gtrain_o[0]), .goa(goa_o[0]), .gog(gog_o[0]), .letter_sel(sel_o[0]),
        .busy(busy_o[0]), .res_valid(rv_o[0]), .res_idx(ridx_o[0]), .res_data(rdat[0]),
        .done(done_o[0])
    );

    perceptron_run_ctrl #(.PHASE_CYC(1), .N_LETTERS(2), .OUT_W(8)) dut1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .train_en(tren_v[1]),
        .abort(abort_v[1]), .net_out(net_v[1]), .write(write_o[1]), .atrain(atrain_o[1]),
        .gtrain(gtrain_o[1]), .goa(goa_o[1]), .gog(gog_o[1]), .letter_sel(sel_o[1]),
        .busy(busy_o[1]), .res_valid(rv_o[1]), .res_idx(ridx_o[1]), .res_data(rdat[1]),
        .done(done_o[1])
    );

    assign obs[0] = {write_o[0], atrain_o[0], gtrain_o[0], goa_o[0], gog_o[0], sel_o[0],
                     busy_o[0], rv_o[0], ridx_o[0], done_o[0]};
    assign obs[1] = {write_o[1], atrain_o[1], gtrain_o[1], goa_o[1], gog_o[1], sel_o[1],
                     busy_o[1], rv_o[1], ridx_o[1], done_o[1]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control outputs in cycle k after start was sampled at edge 0 (cycle k spans edges k-1..k).
    function automatic logic [16:0] exp_ctl(input int p, input int n, input bit tr,
                                            input int k, input int ab_k);
        logic       w, at, ga, gg, bz, rv, dn;
        logic [5:0] sl;
        logic [2:0] ri;
        int base, len, dk, j, i, r;
        w = 0; at = 0; ga = 0; gg = 0; bz = 0; rv = 0; dn = 0; sl = '0; ri = '0;
        if (ab_k >= 0 && k > ab_k) return '0;
        base = tr ? 2 * p + 1 : 1;
        len  = 2 * p + 2;
        dk   = base + n * len;
        w  = tr && k >= 1 && k <= p;
        at = tr && k > p && k <= 2 * p;
        bz = k >= 1 && k <= dk;
        dn = (k == dk);
        if (k >= base && k < dk) begin
            j  = k - base;
            i  = j / len;
            r  = j % len;
            sl = 6'(1 << i);
            ga = r >= 1 && r <= p;
            gg = r > p && r <= 2 * p;
            rv = (r == 2 * p + 1);
            ri = rv ? 3'(i) : 3'd0;
        end
        return {w, at, at, ga, gg, sl, bz, rv, ri, dn};
    endfunction

    // One run on instance inst; ab_k >= 0 kills it with abort (or reset) driven in cycle ab_k.
    task automatic run(input int inst, input bit tr, input int ab_k, input bit spam, input bit use_rst);
        int p, n, base, dk, last;
        logic [16:0] e;
        logic [7:0] hist [0:511];
        p    = inst ? 1 : 12;
        n    = inst ? 2 : 6;
        base = tr ? 2 * p + 1 : 1;
        dk   = base + n * (2 * p + 2);
        last = (ab_k >= 0) ? ab_k + 3 : dk + 2;
        @(posedge clk); #1;
        start_v[inst] = 1'b1;
        tren_v[inst]  = tr;
        net_v[inst]   = 8'($urandom);
        hist[0]       = net_v[inst];
        if (ab_k == 0) begin
            if (use_rst) rst_v[inst] = 1'b1; else abort_v[inst] = 1'b1;
        end
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            start_v[inst] = 1'b0;
            abort_v[inst] = 1'b0;
            rst_v[inst]   = 1'b0;
            e = exp_ctl(p, n, tr, k, ab_k);
            chk("ctl", 32'(obs[inst]), 32'(e));
            if (e[4]) chk("res_data", 32'(rdat[inst]), 32'(hist[k-1]));
            if (use_rst && ab_k >= 0 && k == ab_k + 1) chk("rst_data", 32'(rdat[inst]), 32'd0);
            tren_v[inst] = 1'($urandom);
            net_v[inst]  = 8'($urandom);
            hist[k]      = net_v[inst];
            if (spam && k < dk && (ab_k < 0 || k < ab_k)) start_v[inst] = 1'($urandom);
            if (k == ab_k) begin
                if (use_rst) rst_v[inst] = 1'b1; else abort_v[inst] = 1'b1;
            end
        end
    endtask

    initial begin
        int p, n, base, dk, ab;
        bit tr;
        errs = 0;
        checks = 0;
        rst_v = 2'b11;
        start_v = '0;
        tren_v = '0;
        abort_v = '0;
        net_v[0] = '0;
        net_v[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctl", 32'(obs[i]), 32'd0);
            chk("reset_data", 32'(rdat[i]), 32'd0);
        end

        for (int inst = 0; inst < 2; inst++) begin
            p = inst ? 1 : 12;
            n = inst ? 2 : 6;
            run(inst, 1'b1, -1, 1'b0, 1'b0);
            run(inst, 1'b0, -1, 1'b0, 1'b0);
            run(inst, 1'b1, -1, 1'b1, 1'b0);
            // abort during the third letter's GOA where the letter exists, else the last letter's
            base = 2 * p + 1;
            ab = base + ((n >= 3) ? 2 : n - 1) * (2 * p + 2) + 1 + $urandom_range(0, p - 1);
            run(inst, 1'b1, ab, 1'b0, 1'b0);
            run(inst, 1'b1, 0, 1'b0, 1'b0);
            run(inst, 1'b1, -1, 1'b0, 1'b0);
            run(inst, 1'b0, 1 + $urandom_range(0, n * (2 * p + 2) - 1), 1'b0, 1'b1);
            for (int r = 0; r < 6; r++) begin
                tr   = 1'($urandom);
                base = tr ? 2 * p + 1 : 1;
                dk   = base + n * (2 * p + 2);
                ab   = $urandom_range(0, 1) ? $urandom_range(1, dk) : -1;
                run(inst, tr, ab, 1'($urandom), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
